i2c_target: RTL and testbench

//   I2C target (slave) endpoint: the responder for the team's I2C master bus. Oversamples
//   SCL/SDA on the 50 MHz system clock, detects START/STOP and matches a 7-bit address.

---
 rtl/i2c_target.sv | 234 +++++++++++++++++++++++
 tb/tb_i2c_target.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// write bytes out as a pulse stream and read bytes pulled through a load strobe.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       clk_in,
    input  logic       resetn,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy,
    output logic       rw,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    // Lane 0 is SCL, lane 1 is SDA; everything presets to 1 so reset looks like an idle bus.
    logic [1:0]    sync1_q, sync2_q, filt_q, prev_q;
    logic [CW-1:0] cnt_q [2];

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            filt_q   <= 2'b11;
            prev_q   <= 2'b11;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q <= {sda_in, scl_in};
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic sda_f, scl_rise, scl_fall, sda_rise, sda_fall, scl_steady_hi, start_ev, stop_ev;

    // An SDA edge coinciding with an SCL edge is data, so START/STOP need SCL high on both sides.
    assign sda_f         = filt_q[1];
    assign scl_rise      = filt_q[0] & ~prev_q[0];
    assign scl_fall      = ~filt_q[0] & prev_q[0];
    assign sda_rise      = filt_q[1] & ~prev_q[1];
    assign sda_fall      = ~filt_q[1] & prev_q[1];
    assign scl_steady_hi = filt_q[0] & prev_q[0];
    assign start_ev      = sda_fall & scl_steady_hi;
    assign stop_ev       = sda_rise & scl_steady_hi;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       phase_q, phase_d;
    logic [7:0] shift_q, shift_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       first_byte_q, first_byte_d;

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            phase_q      <= 1'b0;
            shift_q      <= '0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            rw_q         <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_first_q   <= 1'b0;
            first_byte_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            phase_q      <= phase_d;
            shift_q      <= shift_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
            rw_q         <= rw_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_first_q   <= rx_first_d;
            first_byte_q <= first_byte_d;
        end
    end

    // tx_load is a one-cycle strobe with no back-pressure: tx_data is taken in that same
    // cycle, so the source must already hold the next byte whenever a read is in progress.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        phase_d      = phase_q;
        shift_d      = shift_q;
        oe_d         = oe_q;
        busy_d       = busy_q;
        rw_d         = rw_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_first_d   = 1'b0;
        first_byte_d = first_byte_q;
        tx_load      = 1'b0;

        if (stop_ev) begin
            state_d   = IDLE;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
        end else if (start_ev) begin
            state_d   = ADDR;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_q[6:0] == TARGET_ADDR) begin
                                rw_d    = sda_f;
                                phase_d = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end else if (scl_fall && phase_q) begin
                        oe_d    = 1'b1;
                        busy_d  = 1'b1;
                        phase_d = 1'b0;
                        state_d = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            tx_load = 1'b1;
                            shift_d = tx_data;
                            oe_d    = ~tx_data[7];
                            state_d = RD_DATA;
                        end else begin
                            oe_d         = 1'b0;
                            first_byte_d = 1'b1;
                            state_d      = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d    = {shift_q[6:0], sda_f};
                            rx_valid_d   = 1'b1;
                            rx_first_d   = first_byte_q;
                            first_byte_d = 1'b0;
                            phase_d      = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        oe_d    = 1'b1;
                        phase_d = 1'b0;
                        state_d = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        state_d = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            oe_d      = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    // A falling edge here can only follow a rising edge that saw ACK (SDA low).
                    if (scl_rise && sda_f) begin
                        state_d = IGNORE;
                    end else if (scl_fall) begin
                        tx_load   = 1'b1;
                        shift_d   = tx_data;
                        oe_d      = ~tx_data[7];
                        bit_cnt_d = '0;
                        state_d   = RD_DATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sda_oe    = oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_first  = rx_first_q;
    assign busy      = busy_q;
    assign rw        = rw_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: an open-drain master BFM plus a transaction-level model of what the
// target must ACK, emit on rx and consume on tx, checked by one per-cycle monitor.
module tb_i2c_target;
    localparam logic [6:0] TGT = 7'h42;
    localparam int         Q   = 20;   // SCL quarter period in clk cycles

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, rx_valid, rx_first, tx_load, busy, rw;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    logic [2:0] state_dbg;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target dut (
        .clk_in   (clk),
        .resetn   (resetn),
        .scl_in   (scl_m),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .busy     (busy),
        .rw       (rw),
        .state_dbg(state_dbg)
    );

    always #10 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];      // expected {rx_first, rx_data}
    logic [7:0] tx_src_q[$];   // bytes the target must consume, in order
    logic [8:0] rx_log[$];
    logic [7:0] rd_log[$];
    int         ld_cnt = 0;
    bit         drive_ok = 1'b0;
    bit         prev_drive = 1'b0;
    bit         pend_pop = 1'b0;
    logic [7:0] dbuf[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: target may pull SDA only where the model allows it; rx and tx traffic vs queues.
    always @(negedge clk) begin
        if (!resetn) begin
            pend_pop = 1'b0;
        end else begin
            if (pend_pop) begin
                void'(tx_src_q.pop_front());
                pend_pop = 1'b0;
            end
            chk("sda_oe_allowed", {31'd0, sda_oe & ~drive_ok}, 32'd0);
            if (rx_valid) begin
                rx_log.push_back({rx_first, rx_data});
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected", {23'd0, rx_first, rx_data}, 32'h1ff);
                end else begin
                    chk("rx_byte", {23'd0, rx_first, rx_data}, {23'd0, exp_q.pop_front()});
                end
            end
            if (tx_load) begin
                ld_cnt++;
                chk("tx_load_expected", (tx_src_q.size() > 0), 32'd1);
                if (tx_src_q.size() > 0) pend_pop = 1'b1;
            end
        end
        tx_data = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'h00;
    end

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic slot(input bit m_sda, input bit t_drv, output bit seen);
        drive_ok = prev_drive | t_drv;
        wait_q();
        drive_ok = t_drv;
        sda_m = m_sda;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        seen = sda_bus;
        wait_q();
        scl_m = 1'b0;
        prev_drive = t_drv;
    endtask

    task automatic send_start();
        drive_ok = prev_drive;
        wait_q();
        drive_ok = 1'b0;
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
        prev_drive = 1'b0;
    endtask

    task automatic send_stop();
        drive_ok = prev_drive;
        wait_q();
        drive_ok = 1'b0;
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
        prev_drive = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit exp_ack);
        bit seen;
        for (int i = 7; i >= 0; i--) slot(b[i], 1'b0, seen);
        slot(1'b1, exp_ack, seen);
        chk("ack_bit", {31'd0, seen}, {31'd0, ~exp_ack});
    endtask

    task automatic read_byte(input logic [7:0] expv, input bit mack);
        bit seen;
        logic [7:0] v;
        for (int i = 7; i >= 0; i--) begin
            slot(1'b1, ~expv[i], seen);
            v[i] = seen;
        end
        rd_log.push_back(v);
        chk("rd_byte", {24'd0, v}, {24'd0, expv});
        slot(~mack, 1'b0, seen);
    endtask

    // Transaction model: only the matching address is ACKed; writes land on rx in order with
    // the first byte flagged; reads consume one tx byte each; an unanswered read returns 0xFF.
    task automatic txn(input logic [6:0] a, input bit r, input int n, input bit do_stop);
        bit m;
        m = (a == TGT);
        for (int i = 0; i < n; i++) begin
            if (m && !r) exp_q.push_back({(i == 0), dbuf[i]});
            if (m && r) tx_src_q.push_back(dbuf[i]);
        end
        send_start();
        chk("busy_after_start", {31'd0, busy}, 32'd0);
        write_byte({a, r}, m);
        chk("busy_after_addr", {31'd0, busy}, {31'd0, m});
        if (m) chk("rw_latched", {31'd0, rw}, {31'd0, r});
        for (int i = 0; i < n; i++) begin
            if (r) read_byte(m ? dbuf[i] : 8'hFF, (i != n - 1));
            else write_byte(dbuf[i], m);
        end
        if (do_stop) begin
            send_stop();
            repeat (10) @(posedge clk);
            #1;
            chk("busy_after_stop", {31'd0, busy}, 32'd0);
            chk("idle_after_stop", {29'd0, state_dbg}, 32'd0);
        end
        chk("rx_all_seen", exp_q.size(), 32'd0);
        chk("tx_all_used", tx_src_q.size(), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [6:0] a;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_state", {29'd0, state_dbg}, 32'd0);
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Write to our address
        dbuf[0] = 8'hA5; dbuf[1] = 8'h3C;
        rx_log.delete();
        txn(TGT, 1'b0, 2, 1'b1);
        chk("t1_rx_cnt", rx_log.size(), 32'd2);
        if (rx_log.size() == 2) begin
            chk("t1_rx0", {23'd0, rx_log[0]}, 32'h1A5);
            chk("t1_rx1", {23'd0, rx_log[1]}, 32'h03C);
        end

        // Address mismatch
        dbuf[0] = 8'hFF;
        rx_log.delete();
        ld_cnt = 0;
        txn(7'h43, 1'b0, 1, 1'b1);
        chk("t2_no_rx", rx_log.size(), 32'd0);
        chk("t2_no_load", ld_cnt, 32'd0);

        // Read two bytes, ACK then NACK
        dbuf[0] = 8'h5A; dbuf[1] = 8'hC3;
        rd_log.delete();
        ld_cnt = 0;
        txn(TGT, 1'b1, 2, 1'b1);
        chk("t3_loads", ld_cnt, 32'd2);
        if (rd_log.size() == 2) begin
            chk("t3_rd0", {24'd0, rd_log[0]}, 32'h5A);
            chk("t3_rd1", {24'd0, rd_log[1]}, 32'hC3);
        end

        // Repeated START: write then read
        dbuf[0] = 8'h11;
        rx_log.delete();
        txn(TGT, 1'b0, 1, 1'b0);
        chk("t4_rw_w", {31'd0, rw}, 32'd0);
        dbuf[0] = 8'h77;
        rd_log.delete();
        txn(TGT, 1'b1, 1, 1'b1);
        chk("t4_rw_r", {31'd0, rw}, 32'd1);
        if (rx_log.size() == 1) chk("t4_rx", {23'd0, rx_log[0]}, 32'h111);
        else chk("t4_rx_cnt", rx_log.size(), 32'd1);
        if (rd_log.size() == 1) chk("t4_rd", {24'd0, rd_log[0]}, 32'h77);

        // STOP after four bits of a data byte
        rx_log.delete();
        send_start();
        write_byte({TGT, 1'b0}, 1'b1);
        for (int i = 7; i >= 4; i--) slot(dbuf[0][i], 1'b0, seen);
        send_stop();
        repeat (10) @(posedge clk);
        #1;
        chk("t5_idle", {29'd0, state_dbg}, 32'd0);
        chk("t5_no_rx", rx_log.size(), 32'd0);
        dbuf[0] = 8'h96;
        txn(TGT, 1'b0, 1, 1'b1);

        // Reset while the target pulls SDA for a 0 read bit
        tx_src_q.push_back(8'h5A);
        send_start();
        write_byte({TGT, 1'b1}, 1'b1);
        drive_ok = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
        chk("t6_driving", {31'd0, sda_oe}, 32'd1);
        @(posedge clk);
        #7;
        resetn = 1'b0;
        #1;
        chk("t6_rst_oe", {31'd0, sda_oe}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_rw", {31'd0, rw}, 32'd0);
        chk("t6_rst_rx", {22'd0, rx_valid, rx_first, rx_data}, 32'd0);
        chk("t6_rst_load", {31'd0, tx_load}, 32'd0);
        drive_ok = 1'b0;
        prev_drive = 1'b0;
        scl_m = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_tx_used", tx_src_q.size(), 32'd0);
        dbuf[0] = 8'h3E;
        txn(TGT, 1'b0, 1, 1'b1);

        // Randomized transactions
        for (int t = 0; t < 6; t++) begin
            a = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 2) != 0) a = TGT;
            else if (a == TGT) a = a ^ 7'h01;
            for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom_range(0, 255));
            txn(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3),
                (t == 5) ? 1'b1 : 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
